// File: rtl/adder_cpe_pkg.sv
// ============================================================================
// adder_cpe_pkg : shared defaults, result type and generator-matrix builder
// Rev 1.0
// ============================================================================
`default_nettype none

package adder_cpe_pkg;

  localparam int NBIT_DEF  = 7;
  localparam int NCODE_DEF = 15;
  localparam int CNTW_DEF  = 8;
  localparam int GMAT_MAXW = 4096;

  typedef struct packed {
    logic [NBIT_DEF:0]    sum;
    logic [NCODE_DEF-1:0] code;
  } result_t;

  // Rows below nbit form an identity; the remaining rows are parity-of-all rows.
  function automatic logic [GMAT_MAXW-1:0] gmat_default(input int nbit, input int ncode);
    logic [GMAT_MAXW-1:0] m;
    m = '0;
    for (int j = 0; j < ncode; j++) begin
      for (int i = 0; i < nbit; i++) begin
        if (j * nbit + i < GMAT_MAXW) begin
          m[j * nbit + i] = (j < nbit) ? (i == j) : 1'b1;
        end
      end
    end
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cpe_gen.sv
// ============================================================================
// cpe_gen : combinational CPE codeword encoder, code[j] = ^(GMAT row j & x)
// Rev 1.0
// ============================================================================
`default_nettype none

module cpe_gen #(
  parameter int                     NBIT  = 7,
  parameter int                     NCODE = 15,
  parameter logic [NCODE*NBIT-1:0]  GMAT  = '0
) (
  input  logic [NBIT-1:0]  x_i,
  output logic [NCODE-1:0] code_o
);

  for (genvar j = 0; j < NCODE; j++) begin : g_row
    assign code_o[j] = ^(GMAT[j*NBIT +: NBIT] & x_i);
  end

endmodule

`default_nettype wire

// File: rtl/adder_cpe_pipe.sv
// ============================================================================
// adder_cpe_pipe : two-stage add/sub with CPE codeword, checker and fault mask
// Rev 1.0
// ============================================================================
`default_nettype none

module adder_cpe_pipe
  import adder_cpe_pkg::*;
#(
  parameter int                    NBIT  = NBIT_DEF,
  parameter int                    NCODE = NCODE_DEF,
  parameter logic [NCODE*NBIT-1:0] GMAT  = (NCODE*NBIT)'(gmat_default(NBIT, NCODE)),
  parameter int                    CNTW  = CNTW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NBIT-1:0]  a,
  input  logic [NBIT-1:0]  b,
  input  logic             cin,
  input  logic             sub,
  input  logic [NBIT:0]    inj_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBIT:0]    sum,
  output logic [NCODE-1:0] code,
  output logic             err,
  output logic [CNTW-1:0]  err_cnt,
  input  logic             clr_cnt
);

  logic             s1_valid_q;
  logic [NBIT-1:0]  a_q;
  logic [NBIT-1:0]  b_q;
  logic             c_q;
  logic [NBIT:0]    mask_q;

  logic             out_valid_q;
  logic [NBIT:0]    sum_q;
  logic [NCODE-1:0] code_q;
  logic [CNTW-1:0]  err_cnt_q;

  logic             s2_adv;
  logic             accept;
  logic [NBIT:0]    raw_d;
  logic [NCODE-1:0] code_d;
  logic [NCODE-1:0] chk_code;

  assign s2_adv   = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_adv;
  assign accept   = in_valid && in_ready;

  // Subtraction is folded into stage 1 so stage 2 is a plain three-input add.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= 1'b0;
      mask_q     <= '0;
    end else begin
      if (accept) begin
        s1_valid_q <= 1'b1;
        a_q        <= a;
        b_q        <= sub ? ~b : b;
        c_q        <= sub ? 1'b1 : cin;
        mask_q     <= inj_mask;
      end else if (s2_adv) begin
        s1_valid_q <= 1'b0;
      end
    end
  end

  assign raw_d = {1'b0, a_q} + {1'b0, b_q} + {{NBIT{1'b0}}, c_q};

  cpe_gen #(
    .NBIT  (NBIT),
    .NCODE (NCODE),
    .GMAT  (GMAT)
  ) u_enc (
    .x_i    (raw_d[NBIT-1:0]),
    .code_o (code_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      code_q      <= '0;
    end else if (s2_adv) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        sum_q  <= raw_d ^ mask_q;
        code_q <= code_d;
      end
    end
  end

  cpe_gen #(
    .NBIT  (NBIT),
    .NCODE (NCODE),
    .GMAT  (GMAT)
  ) u_chk (
    .x_i    (sum_q[NBIT-1:0]),
    .code_o (chk_code)
  );

  assign err = out_valid_q && (chk_code != code_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (clr_cnt) begin
      err_cnt_q <= '0;
    end else if (out_valid_q && out_ready && err && (err_cnt_q != {CNTW{1'b1}})) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign code      = code_q;
  assign err_cnt   = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_adder_cpe_pipe.sv
// ============================================================================
// tb_adder_cpe_pipe : directed self-checking bench for adder_cpe_pipe
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_adder_cpe_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [6:0]  a;
  logic [6:0]  b;
  logic        cin;
  logic        sub;
  logic [7:0]  inj_mask;
  logic        out_ready;
  logic        clr_cnt;

  logic        in_ready1, out_valid1, err1;
  logic [7:0]  sum1;
  logic [14:0] code1;
  logic [7:0]  cnt1;

  logic        in_ready2, out_valid2, err2;
  logic [7:0]  sum2;
  logic [14:0] code2;
  logic [1:0]  cnt2;

  int ntests = 0;
  int nfail  = 0;

  adder_cpe_pipe u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .cin(cin), .sub(sub), .inj_mask(inj_mask),
    .out_valid(out_valid1), .out_ready(out_ready), .sum(sum1), .code(code1),
    .err(err1), .err_cnt(cnt1), .clr_cnt(clr_cnt)
  );

  adder_cpe_pipe #(.CNTW(2)) u_dut_c2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .cin(cin), .sub(sub), .inj_mask(inj_mask),
    .out_valid(out_valid2), .out_ready(out_ready), .sum(sum2), .code(code2),
    .err(err2), .err_cnt(cnt2), .clr_cnt(clr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [6:0] aa, input logic [6:0] bb,
                       input logic ci, input logic s, input logic [7:0] m);
    in_valid = v;
    a        = aa;
    b        = bb;
    cin      = ci;
    sub      = s;
    inj_mask = m;
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    clr_cnt = 1'b0;
    drive(1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 8'h00);
    tick; tick;
    rst = 1'b0;
    tick;

    chk("rst_out_valid", out_valid1, 0);
    chk("rst_sum",       sum1, 0);
    chk("rst_code",      code1, 0);
    chk("rst_err_cnt",   cnt1, 0);
    chk("rst_in_ready",  in_ready1, 1);
    chk("rst_err",       err1, 0);

    // 5 + 3
    drive(1'b1, 7'd5, 7'd3, 1'b0, 1'b0, 8'h00);
    tick;
    in_valid = 1'b0;
    chk("add1_lat1_valid", out_valid1, 0);
    tick;
    chk("add1_valid", out_valid1, 1);
    chk("add1_sum",   sum1, 32'h08);
    chk("add1_code",  code1, 32'h7F88);
    chk("add1_err",   err1, 0);

    // 127 + 1 then 3 - 5, back to back
    drive(1'b1, 7'd127, 7'd1, 1'b0, 1'b0, 8'h00);
    tick;
    drive(1'b1, 7'd3, 7'd5, 1'b1, 1'b1, 8'h00);
    tick;
    in_valid = 1'b0;
    chk("add2_sum",  sum1, 32'h80);
    chk("add2_code", code1, 32'h0000);
    tick;
    chk("sub_valid", out_valid1, 1);
    chk("sub_sum",   sum1, 32'h7E);
    chk("sub_code",  code1, 32'h007E);
    tick;
    chk("drain_valid", out_valid1, 0);

    // Injection into a data bit
    drive(1'b1, 7'd5, 7'd3, 1'b0, 1'b0, 8'h01);
    tick;
    in_valid = 1'b0;
    tick;
    chk("inj1_sum",  sum1, 32'h09);
    chk("inj1_code", code1, 32'h7F88);
    chk("inj1_err",  err1, 1);
    chk("inj1_cnt_before", cnt1, 0);
    tick;
    chk("inj1_cnt_after", cnt1, 1);

    // Injection into the carry bit only
    drive(1'b1, 7'd5, 7'd3, 1'b0, 1'b0, 8'h80);
    tick;
    in_valid = 1'b0;
    tick;
    chk("inj80_sum", sum1, 32'h88);
    chk("inj80_err", err1, 0);
    tick;
    chk("inj80_cnt", cnt1, 1);

    // Backpressure with three transactions
    out_ready = 1'b0;
    drive(1'b1, 7'd1, 7'd1, 1'b0, 1'b0, 8'h00);
    chk("bp_rdy0", in_ready1, 1);
    tick;
    drive(1'b1, 7'd2, 7'd2, 1'b0, 1'b0, 8'h00);
    chk("bp_rdy1", in_ready1, 1);
    tick;
    drive(1'b1, 7'd3, 7'd3, 1'b0, 1'b0, 8'h00);
    chk("bp_rdy2",  in_ready1, 0);
    chk("bp_x_sum", sum1, 32'h02);
    tick;
    chk("bp_hold_sum",   sum1, 32'h02);
    chk("bp_hold_code",  code1, 32'h7F82);
    chk("bp_hold_valid", out_valid1, 1);
    chk("bp_hold_rdy",   in_ready1, 0);
    tick;
    chk("bp_hold2_sum",  sum1, 32'h02);
    out_ready = 1'b1;
    #1;
    chk("bp_release_rdy", in_ready1, 1);
    tick;
    in_valid = 1'b0;
    chk("bp_y_sum",  sum1, 32'h04);
    chk("bp_y_code", code1, 32'h7F84);
    tick;
    chk("bp_z_sum",  sum1, 32'h06);
    chk("bp_z_code", code1, 32'h0006);
    tick;
    chk("bp_drain", out_valid1, 0);

    // Counter clear, then five errors into both counters
    clr_cnt = 1'b1;
    tick;
    clr_cnt = 1'b0;
    chk("clr_cnt1", cnt1, 0);
    chk("clr_cnt2", cnt2, 0);
    drive(1'b1, 7'd5, 7'd3, 1'b0, 1'b0, 8'h01);
    repeat (5) tick;
    in_valid = 1'b0;
    tick; tick;
    chk("sat_cnt8", cnt1, 5);
    chk("sat_cnt2", cnt2, 3);

    // Clear coincident with an erroring handshake
    drive(1'b1, 7'd5, 7'd3, 1'b0, 1'b0, 8'h01);
    tick;
    in_valid = 1'b0;
    tick;
    chk("clrerr_err", err2, 1);
    clr_cnt = 1'b1;
    tick;
    clr_cnt = 1'b0;
    chk("clrerr_cnt2", cnt2, 0);
    chk("clrerr_cnt1", cnt1, 0);

    // One counted error, then fill both stages and reset asynchronously
    drive(1'b1, 7'd5, 7'd3, 1'b0, 1'b0, 8'h01);
    tick;
    in_valid = 1'b0;
    tick; tick;
    chk("pre_rst_cnt", cnt1, 1);
    out_ready = 1'b0;
    drive(1'b1, 7'd5, 7'd3, 1'b0, 1'b0, 8'h00);
    tick;
    drive(1'b1, 7'd1, 7'd1, 1'b0, 1'b0, 8'h00);
    tick;
    in_valid = 1'b0;
    chk("full_valid", out_valid1, 1);
    chk("full_rdy",   in_ready1, 0);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_valid", out_valid1, 0);
    chk("arst_cnt",   cnt1, 0);
    chk("arst_sum",   sum1, 0);
    chk("arst_code",  code1, 0);
    chk("arst_rdy",   in_ready1, 1);
    tick;
    rst = 1'b0;
    out_ready = 1'b1;
    tick;
    chk("post_rst_valid", out_valid1, 0);
    drive(1'b1, 7'd5, 7'd3, 1'b0, 1'b0, 8'h00);
    tick;
    in_valid = 1'b0;
    chk("post_rst_lat1", out_valid1, 0);
    tick;
    chk("post_rst_lat2", out_valid1, 1);
    chk("post_rst_sum",  sum1, 32'h08);
    chk("post_rst_code", code1, 32'h7F88);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

`default_nettype wire
